pic_exec_unit: RTL and testbench
================================

Name: pic_exec_unit

Overview:
Execute stage of a PIC16-style 8-bit core. It decodes the upper 8 bits of a 14-bit opcode, selects the ALU B operand (file value or literal), and computes the result. It holds the carry (C) and zero (Z) status flags in registers. It sits between the instruction register (opcode[13:6], literal k) and the W register / file write-back, and merges the roles of decode, operand mux and ALU.

Parameters:
WIDTH, 8, datapath width; only 8 is supported.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears the status flags
inst_reg  in  8  opcode[13:6]
k  in  8  literal, opcode[7:0]
f  in  8  addressed file-register value
w  in  8  current W register value
ans  out  8  ALU result (combinational)
d  out  1  destination: 1 = file, 0 = W
wr  out  1  result must be written to the destination
switch_a_m  out  1  B-operand select: 1 = k, 0 = f
bit_number  out  3  bit index for bit-oriented instructions
skip  out  1  next instruction must be skipped (combinational)
c_flag  out  1  registered carry flag
z_flag  out  1  registered zero flag

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high. On reset, c_flag=0 and z_flag=0. All other outputs are combinational and do not depend on reset.
- Operand selection: a=w; b = switch_a_m ? k : f.
- Instruction class is inst_reg[7:6]:
  - 00 byte-file: op=[5:2], d=[1]. switch_a_m=0. wr=1 except NOP (op 0000 with d=0).
    - 0111 ADD: b+a
    - 0010 SUB: b-a
    - 0101 AND; 0100 IOR; 0110 XOR
    - 1000 MOVF: b
    - 0000 MOVWF (d=1) / NOP (d=0): ans=a
    - 0001 CLR: 0
    - 1001 COM: ~b
    - 1010 INC: b+1; 1111 INCFSZ: b+1
    - 0011 DEC: b-1; 1011 DECFSZ: b-1
    - 1101 RLF: {b[6:0],C}
    - 1100 RRF: {C,b[7:1]}
    - 1110 SWAP: {b[3:0],b[7:4]}
  - 01 bit: op=[5:4], bit_number=[3:1]. switch_a_m=0. d=1.
    - 00 BCF: clear bit in b
    - 01 BSF: set bit in b
    - 10 BTFSC / 11 BTFSS: ans=b, wr=0
  - 11 literal: op=[5:2]. switch_a_m=1. d=0. wr=1.
    - 00xx MOVLW, 01xx RETLW: ans=k
    - 1000 IORLW; 1001 ANDLW; 1010 XORLW
    - 110x SUBLW: k-w
    - 111x ADDLW
    - 1011 is unused: ans=w, wr=0, no flag change.
  - 10 (CALL/GOTO): ans=w, d=0, wr=0, switch_a_m=1, no flag change.
- Arithmetic: 8-bit modulo arithmetic; results wrap.
  - ADD: C = carry-out of bit 7.
  - SUB: C = 1 when no borrow (b>=a).
  - RLF/RRF: C = the bit shifted out; the C shifted in is the current c_flag.
- Flag update on the next rising clk edge while the instruction is presented:
  - Z = (ans==0) for ADD, SUB, AND, IOR, XOR, CLR, COM, INC, DEC, MOVF, and the literal ALU ops.
  - C for ADD, SUB, ADDLW, SUBLW, RLF, RRF.
  - All other instructions hold both flags.
  - reset has priority over a flag update in the same cycle.
- skip:
  - BTFSC: 1 when b[bit]==0.
  - BTFSS: 1 when b[bit]==1.
  - INCFSZ/DECFSZ: 1 when ans==0.
  - Otherwise 0.
- Unused bit fields (d in bit and literal classes, bit_number outside the bit class) drive 0.

Decomposition:
- Package pic_exec_pkg:
  - alu_op_e, 4-bit internal ALU op: ADD, SUB, AND, IOR, XOR, PASS_A, PASS_B, CLR, COM, INC, DEC, RL, RR, SWAP, BCLR, BSET.
  - Class codes: CLS_BYTE=2'b00, CLS_BIT=2'b01, CLS_CTRL=2'b10, CLS_LIT=2'b11.
- Sub-module pic_alu_core: purely combinational; inputs alu_op_e, a, b, bit_number, c_in; outputs ans, c_out, z.
- The top level holds the decoder, the operand mux, the flag registers and the skip logic.

Test Plan:
- Reset: reset=1 for one clk -> c_flag=0, z_flag=0. Release; inst_reg=0x1C (ADDWF, d=0), f=10, w=5 -> ans=15, d=0, wr=1, switch_a_m=0; after clk C=0, Z=0.
- Overflow: inst_reg=0x1E (ADDWF, d=1), f=0xFF, w=1 -> ans=0x00, d=1; after clk C=1, Z=1. Then inst_reg=0xC0 (MOVLW), k=3 -> ans=3, switch_a_m=1, d=0; flags hold 1/1.
- Bit ops: inst_reg=0x40 (BCF bit 0), f=0x0F -> ans=0x0E, d=1, bit_number=0. inst_reg=0x54 (BSF bit 2), f=0x00 -> ans=0x04, bit_number=2. inst_reg=0x7E (BTFSS bit 7), f=0x80 -> skip=1, wr=0.
- Subtract and borrow: inst_reg=0xF0 (SUBLW), k=3, w=5 -> ans=0xFE; after clk C=0, Z=0. Then k=5, w=5 -> ans=0; after clk C=1, Z=1.
- Rotate through carry: with C=0, inst_reg=0x32 (RRF, d=1), f=0x01 -> ans=0x00; after clk C=1. Then inst_reg=0x36 (RLF, d=1), f=0x80 -> ans=0x01; after clk C=1.
- Skip counter: inst_reg=0x2E (DECFSZ, d=1), f=1 -> ans=0, skip=1, flags unchanged. With f=2 -> ans=1, skip=0.

Source files
------------

// File: rtl/pic_exec_pkg.sv
// rtl/pic_exec_pkg.sv - shared types and class codes for the PIC16-style execute stage
package pic_exec_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_IOR,
    ALU_XOR,
    ALU_PASS_A,
    ALU_PASS_B,
    ALU_CLR,
    ALU_COM,
    ALU_INC,
    ALU_DEC,
    ALU_RL,
    ALU_RR,
    ALU_SWAP,
    ALU_BCLR,
    ALU_BSET
  } alu_op_e;

  localparam logic [1:0] CLS_BYTE = 2'b00;
  localparam logic [1:0] CLS_BIT  = 2'b01;
  localparam logic [1:0] CLS_CTRL = 2'b10;
  localparam logic [1:0] CLS_LIT  = 2'b11;

  typedef struct packed {
    alu_op_e    op;
    logic       d;
    logic       wr;
    logic       sel_k;
    logic [2:0] bit_number;
    logic       upd_c;
    logic       upd_z;
    logic       skip_zero;
    logic       skip_bclr;
    logic       skip_bset;
  } ctrl_t;

endpackage

// File: rtl/pic_alu_core.sv
// rtl/pic_alu_core.sv - combinational 8-bit ALU; c_out is only meaningful for ADD/SUB/RL/RR
module pic_alu_core
  import pic_exec_pkg::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] bit_number,
  input  logic       c_in,
  output logic [7:0] ans,
  output logic       c_out,
  output logic       z
);

  logic [8:0] sum;
  logic [7:0] mask;

  assign mask = 8'b0000_0001 << bit_number;

  always_comb begin
    sum   = 9'd0;
    ans   = b;
    c_out = c_in;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, b} + {1'b0, a};
        ans   = sum[7:0];
        c_out = sum[8];
      end
      ALU_SUB: begin
        // borrow lands in bit 8; carry means "no borrow"
        sum   = {1'b0, b} - {1'b0, a};
        ans   = sum[7:0];
        c_out = ~sum[8];
      end
      ALU_AND:    ans = b & a;
      ALU_IOR:    ans = b | a;
      ALU_XOR:    ans = b ^ a;
      ALU_PASS_A: ans = a;
      ALU_PASS_B: ans = b;
      ALU_CLR:    ans = 8'h00;
      ALU_COM:    ans = ~b;
      ALU_INC:    ans = b + 8'd1;
      ALU_DEC:    ans = b - 8'd1;
      ALU_RL: begin
        ans   = {b[6:0], c_in};
        c_out = b[7];
      end
      ALU_RR: begin
        ans   = {c_in, b[7:1]};
        c_out = b[0];
      end
      ALU_SWAP:   ans = {b[3:0], b[7:4]};
      ALU_BCLR:   ans = b & ~mask;
      ALU_BSET:   ans = b | mask;
      default:    ans = b;
    endcase
  end

  assign z = (ans == 8'h00);

endmodule

// File: rtl/pic_exec_unit.sv
// rtl/pic_exec_unit.sv - execute stage: decode of opcode[13:6], operand mux, ALU, C/Z flags, skip
module pic_exec_unit
  import pic_exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       inst_reg,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] ans,
  output logic             d,
  output logic             wr,
  output logic             switch_a_m,
  output logic [2:0]       bit_number,
  output logic             skip,
  output logic             c_flag,
  output logic             z_flag
);

  ctrl_t      ctrl;
  logic [7:0] b_opnd;
  logic       alu_c;
  logic       alu_z;

  always_comb begin
    ctrl            = '0;
    ctrl.op         = ALU_PASS_A;
    case (inst_reg[7:6])
      CLS_BYTE: begin
        ctrl.d  = inst_reg[1];
        ctrl.wr = 1'b1;
        case (inst_reg[5:2])
          4'b0000: begin ctrl.op = ALU_PASS_A; ctrl.wr = inst_reg[1]; end
          4'b0001: begin ctrl.op = ALU_CLR;    ctrl.upd_z = 1'b1; end
          4'b0010: begin ctrl.op = ALU_SUB;    ctrl.upd_c = 1'b1; ctrl.upd_z = 1'b1; end
          4'b0011: begin ctrl.op = ALU_DEC;    ctrl.upd_z = 1'b1; end
          4'b0100: begin ctrl.op = ALU_IOR;    ctrl.upd_z = 1'b1; end
          4'b0101: begin ctrl.op = ALU_AND;    ctrl.upd_z = 1'b1; end
          4'b0110: begin ctrl.op = ALU_XOR;    ctrl.upd_z = 1'b1; end
          4'b0111: begin ctrl.op = ALU_ADD;    ctrl.upd_c = 1'b1; ctrl.upd_z = 1'b1; end
          4'b1000: begin ctrl.op = ALU_PASS_B; ctrl.upd_z = 1'b1; end
          4'b1001: begin ctrl.op = ALU_COM;    ctrl.upd_z = 1'b1; end
          4'b1010: begin ctrl.op = ALU_INC;    ctrl.upd_z = 1'b1; end
          4'b1011: begin ctrl.op = ALU_DEC;    ctrl.skip_zero = 1'b1; end
          4'b1100: begin ctrl.op = ALU_RR;     ctrl.upd_c = 1'b1; end
          4'b1101: begin ctrl.op = ALU_RL;     ctrl.upd_c = 1'b1; end
          4'b1110: begin ctrl.op = ALU_SWAP; end
          default: begin ctrl.op = ALU_INC;    ctrl.skip_zero = 1'b1; end
        endcase
      end
      CLS_BIT: begin
        ctrl.d          = 1'b1;
        ctrl.bit_number = inst_reg[3:1];
        case (inst_reg[5:4])
          2'b00:   begin ctrl.op = ALU_BCLR;   ctrl.wr = 1'b1; end
          2'b01:   begin ctrl.op = ALU_BSET;   ctrl.wr = 1'b1; end
          2'b10:   begin ctrl.op = ALU_PASS_B; ctrl.skip_bclr = 1'b1; end
          default: begin ctrl.op = ALU_PASS_B; ctrl.skip_bset = 1'b1; end
        endcase
      end
      CLS_LIT: begin
        ctrl.sel_k = 1'b1;
        ctrl.wr    = 1'b1;
        casez (inst_reg[5:2])
          4'b0???: ctrl.op = ALU_PASS_B;
          4'b1000: begin ctrl.op = ALU_IOR; ctrl.upd_z = 1'b1; end
          4'b1001: begin ctrl.op = ALU_AND; ctrl.upd_z = 1'b1; end
          4'b1010: begin ctrl.op = ALU_XOR; ctrl.upd_z = 1'b1; end
          4'b1011: begin ctrl.op = ALU_PASS_A; ctrl.wr = 1'b0; end
          4'b110?: begin ctrl.op = ALU_SUB; ctrl.upd_c = 1'b1; ctrl.upd_z = 1'b1; end
          default: begin ctrl.op = ALU_ADD; ctrl.upd_c = 1'b1; ctrl.upd_z = 1'b1; end
        endcase
      end
      default: begin
        // CALL/GOTO: the sequencer owns these; the datapath just passes W through
        ctrl.op    = ALU_PASS_A;
        ctrl.sel_k = 1'b1;
      end
    endcase
  end

  assign b_opnd = ctrl.sel_k ? k : f;

  pic_alu_core u_alu (
    .op         (ctrl.op),
    .a          (w),
    .b          (b_opnd),
    .bit_number (ctrl.bit_number),
    .c_in       (c_flag),
    .ans        (ans),
    .c_out      (alu_c),
    .z          (alu_z)
  );

  assign d          = ctrl.d;
  assign wr         = ctrl.wr;
  assign switch_a_m = ctrl.sel_k;
  assign bit_number = ctrl.bit_number;
  assign skip       = (ctrl.skip_zero & alu_z)
                    | (ctrl.skip_bclr & ~b_opnd[ctrl.bit_number])
                    | (ctrl.skip_bset &  b_opnd[ctrl.bit_number]);

  always_ff @(posedge clk) begin
    if (reset) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (ctrl.upd_c) c_flag <= alu_c;
      if (ctrl.upd_z) z_flag <= alu_z;
    end
  end

endmodule

// File: tb/tb_pic_exec_unit.sv
// tb/tb_pic_exec_unit.sv - directed and randomized checks of pic_exec_unit against an instruction-level model
module tb_pic_exec_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] inst_reg = 8'h00;
  logic [7:0] k = 8'h00;
  logic [7:0] f = 8'h00;
  logic [7:0] w = 8'h00;
  logic [7:0] ans;
  logic       d;
  logic       wr;
  logic       switch_a_m;
  logic [2:0] bit_number;
  logic       skip;
  logic       c_flag;
  logic       z_flag;

  int total = 0;
  int bad   = 0;

  int mc;
  int mz;

  always #5 clk = ~clk;

  pic_exec_unit #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_reg   (inst_reg),
    .k          (k),
    .f          (f),
    .w          (w),
    .ans        (ans),
    .d          (d),
    .wr         (wr),
    .switch_a_m (switch_a_m),
    .bit_number (bit_number),
    .skip       (skip),
    .c_flag     (c_flag),
    .z_flag     (z_flag)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input int kk, input int ff, input int ww);
    inst_reg = i[7:0];
    k        = kk[7:0];
    f        = ff[7:0];
    w        = ww[7:0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: works from the opcode tables with integer arithmetic.
  task automatic model(input int i, input int kv, input int fv, input int wv, input int cin,
                       output int e_ans, output int e_d, output int e_wr, output int e_sw,
                       output int e_bn, output int e_skip,
                       output int set_c, output int new_c, output int set_z);
    int cls, op, bn, tmp, a, b;
    cls = i / 64;
    e_d = 0; e_wr = 0; e_sw = 0; e_bn = 0; e_skip = 0;
    set_c = 0; new_c = 0; set_z = 0;
    a = wv;
    e_ans = wv;
    if (cls == 0) begin
      b = fv;
      op = (i / 4) % 16;
      e_d = (i / 2) % 2;
      e_wr = 1;
      case (op)
        7:  begin tmp = b + a; e_ans = tmp % 256; set_c = 1; new_c = (tmp > 255); set_z = 1; end
        2:  begin tmp = b - a; e_ans = (tmp + 256) % 256; set_c = 1; new_c = (b >= a); set_z = 1; end
        5:  begin e_ans = b & a; set_z = 1; end
        4:  begin e_ans = b | a; set_z = 1; end
        6:  begin e_ans = b ^ a; set_z = 1; end
        8:  begin e_ans = b; set_z = 1; end
        0:  begin e_ans = a; e_wr = e_d; end
        1:  begin e_ans = 0; set_z = 1; end
        9:  begin e_ans = 255 - b; set_z = 1; end
        10: begin e_ans = (b + 1) % 256; set_z = 1; end
        15: begin e_ans = (b + 1) % 256; e_skip = (e_ans == 0); end
        3:  begin e_ans = (b + 255) % 256; set_z = 1; end
        11: begin e_ans = (b + 255) % 256; e_skip = (e_ans == 0); end
        13: begin e_ans = (b * 2) % 256 + cin; set_c = 1; new_c = b / 128; end
        12: begin e_ans = cin * 128 + b / 2; set_c = 1; new_c = b % 2; end
        default: e_ans = (b % 16) * 16 + b / 16;
      endcase
    end else if (cls == 1) begin
      b = fv;
      op = (i / 16) % 4;
      e_bn = (i / 2) % 8;
      e_d = 1;
      tmp = (b >> e_bn) % 2;
      case (op)
        0: begin e_ans = tmp ? b - (1 << e_bn) : b; e_wr = 1; end
        1: begin e_ans = tmp ? b : b + (1 << e_bn); e_wr = 1; end
        2: begin e_ans = b; e_skip = (tmp == 0); end
        default: begin e_ans = b; e_skip = (tmp == 1); end
      endcase
    end else if (cls == 3) begin
      b = kv;
      e_sw = 1;
      e_wr = 1;
      op = (i / 4) % 16;
      if (op < 8) e_ans = b;
      else if (op == 8)  begin e_ans = b | a; set_z = 1; end
      else if (op == 9)  begin e_ans = b & a; set_z = 1; end
      else if (op == 10) begin e_ans = b ^ a; set_z = 1; end
      else if (op == 11) begin e_ans = a; e_wr = 0; end
      else if (op < 14)  begin e_ans = (b - a + 256) % 256; set_c = 1; new_c = (b >= a); set_z = 1; end
      else begin tmp = b + a; e_ans = tmp % 256; set_c = 1; new_c = (tmp > 255); set_z = 1; end
    end else begin
      e_sw = 1;
    end
  endtask

  initial begin
    int e_ans, e_d, e_wr, e_sw, e_bn, e_skip, set_c, new_c, set_z;
    int ri, rk, rf, rw, rr;

    // reset
    reset = 1'b1;
    drive(8'h00, 0, 0, 0);
    tick();
    chk("rst_c", {7'd0, c_flag}, 8'd0);
    chk("rst_z", {7'd0, z_flag}, 8'd0);
    reset = 1'b0;

    // ADDWF d=0
    drive(8'h1C, 0, 10, 5);
    chk("add_ans", ans, 8'd15);
    chk("add_d", {7'd0, d}, 8'd0);
    chk("add_wr", {7'd0, wr}, 8'd1);
    chk("add_sw", {7'd0, switch_a_m}, 8'd0);
    tick();
    chk("add_c", {7'd0, c_flag}, 8'd0);
    chk("add_z", {7'd0, z_flag}, 8'd0);

    // ADDWF overflow d=1
    drive(8'h1E, 0, 8'hFF, 1);
    chk("ovf_ans", ans, 8'h00);
    chk("ovf_d", {7'd0, d}, 8'd1);
    tick();
    chk("ovf_c", {7'd0, c_flag}, 8'd1);
    chk("ovf_z", {7'd0, z_flag}, 8'd1);

    // MOVLW holds flags
    drive(8'hC0, 3, 0, 1);
    chk("movlw_ans", ans, 8'd3);
    chk("movlw_sw", {7'd0, switch_a_m}, 8'd1);
    chk("movlw_d", {7'd0, d}, 8'd0);
    tick();
    chk("movlw_c", {7'd0, c_flag}, 8'd1);
    chk("movlw_z", {7'd0, z_flag}, 8'd1);

    // bit ops
    drive(8'h40, 0, 8'h0F, 0);
    chk("bcf_ans", ans, 8'h0E);
    chk("bcf_d", {7'd0, d}, 8'd1);
    chk("bcf_bn", {5'd0, bit_number}, 8'd0);
    drive(8'h54, 0, 8'h00, 0);
    chk("bsf_ans", ans, 8'h04);
    chk("bsf_bn", {5'd0, bit_number}, 8'd2);
    drive(8'h7E, 0, 8'h80, 0);
    chk("btfss_skip", {7'd0, skip}, 8'd1);
    chk("btfss_wr", {7'd0, wr}, 8'd0);
    tick();

    // SUBLW borrow / equal
    drive(8'hF0, 3, 0, 5);
    chk("sub_ans", ans, 8'hFE);
    tick();
    chk("sub_c", {7'd0, c_flag}, 8'd0);
    chk("sub_z", {7'd0, z_flag}, 8'd0);
    drive(8'hF0, 5, 0, 5);
    chk("sub0_ans", ans, 8'h00);
    tick();
    chk("sub0_c", {7'd0, c_flag}, 8'd1);
    chk("sub0_z", {7'd0, z_flag}, 8'd1);

    // get C=0, Z=0 before rotates
    drive(8'hF0, 3, 0, 5);
    tick();
    drive(8'h32, 0, 8'h01, 0);
    chk("rrf_ans", ans, 8'h00);
    tick();
    chk("rrf_c", {7'd0, c_flag}, 8'd1);
    drive(8'h36, 0, 8'h80, 0);
    chk("rlf_ans", ans, 8'h01);
    tick();
    chk("rlf_c", {7'd0, c_flag}, 8'd1);

    // DECFSZ
    drive(8'h2E, 0, 1, 0);
    chk("decfsz_ans", ans, 8'h00);
    chk("decfsz_skip", {7'd0, skip}, 8'd1);
    tick();
    chk("decfsz_c", {7'd0, c_flag}, 8'd1);
    chk("decfsz_z", {7'd0, z_flag}, 8'd0);
    drive(8'h2E, 0, 2, 0);
    chk("decfsz2_ans", ans, 8'h01);
    chk("decfsz2_skip", {7'd0, skip}, 8'd0);
    tick();

    // randomized against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mc = 0;
    mz = 0;
    for (int n = 0; n < 400; n++) begin
      ri = int'($urandom_range(0, 255));
      rk = int'($urandom_range(0, 255));
      rf = int'($urandom_range(0, 255));
      rw = int'($urandom_range(0, 255));
      if (n % 5 == 0) rf = rw;
      if (n % 7 == 0) rf = int'($urandom_range(0, 1)) * 255;
      rr = ($urandom_range(0, 19) == 0) ? 1 : 0;
      reset = rr[0];
      drive(ri, rk, rf, rw);
      model(ri, rk, rf, rw, mc, e_ans, e_d, e_wr, e_sw, e_bn, e_skip, set_c, new_c, set_z);
      chk($sformatf("rnd_ans op=%0h", ri), ans, e_ans[7:0]);
      chk($sformatf("rnd_d op=%0h", ri), {7'd0, d}, e_d[7:0]);
      chk($sformatf("rnd_wr op=%0h", ri), {7'd0, wr}, e_wr[7:0]);
      chk($sformatf("rnd_sw op=%0h", ri), {7'd0, switch_a_m}, e_sw[7:0]);
      chk($sformatf("rnd_bn op=%0h", ri), {5'd0, bit_number}, e_bn[7:0]);
      chk($sformatf("rnd_skip op=%0h", ri), {7'd0, skip}, e_skip[7:0]);
      if (rr == 1) begin
        mc = 0;
        mz = 0;
      end else begin
        if (set_c == 1) mc = new_c;
        if (set_z == 1) mz = (e_ans == 0) ? 1 : 0;
      end
      tick();
      chk($sformatf("rnd_c op=%0h", ri), {7'd0, c_flag}, mc[7:0]);
      chk($sformatf("rnd_z op=%0h", ri), {7'd0, z_flag}, mz[7:0]);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
